pll_drp_ctrl: RTL and testbench

- DRP initiator driving the dynamic reconfiguration port of a PLLE4_ADV (DADDR/DI/DO/DEN/DWE/DRDY), replacing the tied-off DRP inputs currently used on the PLL.
- Performs one masked read-modify-write of a single PLL register per request, optionally holding the PLL in reset around the write and waiting for re-lock.
- Sits in the fabric clock domain that also clocks the PLL DCLK; upstream logic issues requests via valid/ready and receives a one-cycle response.

---
 rtl/pll_drp_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// pll_drp_ctrl : masked read-modify-write initiator for the PLLE4 DRP port
// Revision     : 1.0
// ============================================================================
module pll_drp_ctrl #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 16,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_mask,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  req_reset_pll,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_WIDTH-1:0] drp_daddr,
  output logic [DATA_WIDTH-1:0] drp_di,
  input  logic [DATA_WIDTH-1:0] drp_do,
  output logic                  drp_den,
  output logic                  drp_dwe,
  input  logic                  drp_drdy,
  output logic                  pll_rst,
  input  logic                  pll_locked
);

  localparam int C_MAXC = (LOCK_TIMEOUT > DRDY_TIMEOUT) ?
                          ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD) :
                          ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
  localparam int C_CW = $clog2(C_MAXC + 1);

  localparam logic [C_CW-1:0] C_DRDY_LAST = C_CW'(DRDY_TIMEOUT - 1);
  localparam logic [C_CW-1:0] C_LOCK_LAST = C_CW'(LOCK_TIMEOUT - 1);
  localparam logic [C_CW-1:0] C_HOLD_LAST = C_CW'(RST_HOLD - 1);
  localparam logic [C_CW-1:0] C_LOCK_MASK = C_CW'(2);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HOLD    = 4'd1,
    S_RD      = 4'd2,
    S_RD_WAIT = 4'd3,
    S_WR      = 4'd4,
    S_WR_WAIT = 4'd5,
    S_RELEASE = 4'd6,
    S_LOCK    = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t                state_q;
  logic [C_CW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  reset_pll_q;
  logic                  hold_q;
  logic [1:0]            err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] daddr_q;
  logic [DATA_WIDTH-1:0] di_q;
  logic                  den_q;
  logic                  dwe_q;
  logic                  ready_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] wdata_d;

  // Mask bit 1 keeps the value read from the PLL, 0 takes the requested bit.
  assign wdata_d = (drp_do & mask_q) | (data_q & ~mask_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      data_q       <= '0;
      reset_pll_q  <= 1'b0;
      hold_q       <= 1'b0;
      err_q        <= 2'd0;
      rdata_q      <= '0;
      daddr_q      <= '0;
      di_q         <= '0;
      den_q        <= 1'b0;
      dwe_q        <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      den_q        <= 1'b0;
      dwe_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            ready_q     <= 1'b0;
            daddr_q     <= req_addr;
            mask_q      <= req_mask;
            data_q      <= req_data;
            reset_pll_q <= req_reset_pll;
            err_q       <= 2'd0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            if (req_reset_pll) begin
              hold_q  <= 1'b1;
              state_q <= S_HOLD;
            end else begin
              den_q   <= 1'b1;
              state_q <= S_RD;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == C_HOLD_LAST) begin
            cnt_q   <= '0;
            den_q   <= 1'b1;
            state_q <= S_RD;
          end else begin
            cnt_q <= cnt_q + C_CW'(1);
          end
        end
        S_RD: begin
          cnt_q   <= '0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (drp_drdy) begin
            rdata_q <= drp_do;
            di_q    <= wdata_d;
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            state_q <= S_WR;
          end else if (cnt_q == C_DRDY_LAST) begin
            err_q   <= 2'd1;
            hold_q  <= 1'b0;
            state_q <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q + C_CW'(1);
          end
        end
        S_WR: begin
          cnt_q   <= '0;
          state_q <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (drp_drdy) begin
            hold_q  <= 1'b0;
            state_q <= S_RELEASE;
          end else if (cnt_q == C_DRDY_LAST) begin
            err_q   <= 2'd1;
            hold_q  <= 1'b0;
            state_q <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q + C_CW'(1);
          end
        end
        S_RELEASE: begin
          hold_q <= 1'b0;
          cnt_q  <= '0;
          if (reset_pll_q && (err_q == 2'd0)) begin
            state_q <= S_LOCK;
          end else begin
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_LOCK: begin
          // The first cycles are skipped so a LOCKED still high from before the reset is not trusted.
          if ((cnt_q >= C_LOCK_MASK) && pll_locked) begin
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else if (cnt_q == C_LOCK_LAST) begin
            err_q        <= 2'd2;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q + C_CW'(1);
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          hold_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign drp_daddr  = daddr_q;
  assign drp_di     = di_q;
  assign drp_den    = den_q;
  assign drp_dwe    = dwe_q;
  assign pll_rst    = rst | hold_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pll_drp_ctrl : directed bench with a DRP register model and PLL lock model
// Revision        : 1.0
// ============================================================================
module tb_pll_drp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_addr;
  logic [15:0] req_mask;
  logic [15:0] req_data;
  logic        req_reset_pll;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_den;
  logic        drp_dwe;
  logic        drp_drdy;
  logic        pll_rst;
  logic        pll_locked;

  logic        drdy_s;
  logic        stray_drdy;
  assign drp_drdy = drdy_s | stray_drdy;

  pll_drp_ctrl #(
    .ADDR_WIDTH(7), .DATA_WIDTH(16), .DRDY_TIMEOUT(16), .LOCK_TIMEOUT(100), .RST_HOLD(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_mask(req_mask), .req_data(req_data), .req_reset_pll(req_reset_pll),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_drdy(drp_drdy), .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // DRP slave / PLL model state
  logic [15:0] mem [0:127];
  int          drdy_k  = 3;
  bit          drdy_en = 1'b1;
  bit          lock_en = 1'b1;
  int          pend = 0;
  logic        p_we;
  logic [6:0]  p_addr;
  logic [15:0] p_di;
  bit          prev_den = 1'b0;
  bit          outstanding = 1'b0;
  int          viol = 0;
  int          den_count = 0;
  int          wr_count = 0;
  int          resp_count = 0;
  int          rst_high = 0;
  int          rst_run = 0;
  int          rd_rst_run = 0;
  logic [6:0]  last_wr_addr;
  logic [15:0] last_wr_di;
  logic        rst_at_wr_drdy;
  logic        rst_after_wr_drdy;
  bit          wr_follow = 1'b0;
  int          lock_cnt = 0;

  initial begin
    drdy_s = 1'b0; drp_do = '0; pll_locked = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (wr_follow) begin rst_after_wr_drdy = pll_rst; wr_follow = 1'b0; end
      drdy_s = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drdy_s = 1'b1;
          outstanding = 1'b0;
          if (p_we) begin
            mem[p_addr] = p_di;
            rst_at_wr_drdy = pll_rst;
            wr_follow = 1'b1;
          end else begin
            drp_do = mem[p_addr];
          end
        end
      end
      if (drp_den === 1'b1) begin
        if (prev_den || outstanding) viol++;
        den_count++;
        outstanding = 1'b1;
        if (drp_dwe === 1'b1) begin
          wr_count++; last_wr_addr = drp_daddr; last_wr_di = drp_di;
        end else begin
          rd_rst_run = rst_run;
        end
        p_we = drp_dwe; p_addr = drp_daddr; p_di = drp_di;
        if (drdy_en) pend = drdy_k;
      end
      prev_den = (drp_den === 1'b1);
      if (resp_valid === 1'b1) begin resp_count++; outstanding = 1'b0; end
      if (pll_rst === 1'b1) begin rst_run++; rst_high++; end else rst_run = 0;
      if (pll_rst !== 1'b0 || !lock_en) begin
        pll_locked = 1'b0; lock_cnt = 0;
      end else if (lock_cnt < 10) begin
        lock_cnt++;
        if (lock_cnt == 10) pll_locked = 1'b1;
      end
    end
  end

  task automatic do_req(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                        input logic rp, output bit got, output logic [15:0] rd,
                        output logic [1:0] er, output int lat);
    int c0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_mask = m; req_data = d; req_reset_pll = rp;
    c0 = cyc; got = 1'b0; rd = 'x; er = 'x; lat = -1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin got = 1'b1; rd = resp_rdata; er = resp_err; lat = cyc - c0; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_mask = '0; req_data = '0;
    req_reset_pll = 1'b0; stray_drdy = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
    total++; if (resp_err !== 2'd0) begin bad++; $display("FAIL rst_err got=%0d exp=0", resp_err); end
    total++; if ({drp_den, drp_dwe} !== 2'b00) begin bad++; $display("FAIL rst_den_dwe got=%b exp=00", {drp_den, drp_dwe}); end
    total++; if (drp_daddr !== 7'h0) begin bad++; $display("FAIL rst_daddr got=%h exp=0", drp_daddr); end
    total++; if (drp_di !== 16'h0) begin bad++; $display("FAIL rst_di got=%h exp=0", drp_di); end
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL rst_pll_rst_high got=%b exp=1", pll_rst); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL rst_pll_rst_low got=%b exp=0", pll_rst); end
  endtask

  task automatic test_mask_write();
    bit got; logic [15:0] rd; logic [1:0] er; int lat; int rh0, wc0;
    repeat (12) @(negedge clk);
    mem[8] = 16'h1234; drdy_k = 3; rh0 = rst_high; wc0 = wr_count;
    do_req(7'h08, 16'hFF00, 16'h0056, 1'b0, got, rd, er, lat);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL mw_resp got=%b exp=1", got); end
    total++; if (lat !== 10) begin bad++; $display("FAIL mw_latency got=%0d exp=10", lat); end
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL mw_rdata got=%h exp=1234", rd); end
    total++; if (er !== 2'd0) begin bad++; $display("FAIL mw_err got=%0d exp=0", er); end
    total++; if (last_wr_di !== 16'h1256) begin bad++; $display("FAIL mw_wdata got=%h exp=1256", last_wr_di); end
    total++; if (last_wr_addr !== 7'h08) begin bad++; $display("FAIL mw_waddr got=%h exp=08", last_wr_addr); end
    total++; if (wr_count - wc0 !== 1) begin bad++; $display("FAIL mw_wr_count got=%0d exp=1", wr_count - wc0); end
    total++; if (rst_high - rh0 !== 0) begin bad++; $display("FAIL mw_pll_rst got=%0d exp=0", rst_high - rh0); end
    drdy_k = 1;
    mem[7'h10] = 16'hABCD;
    do_req(7'h10, 16'h0F0F, 16'h1234, 1'b0, got, rd, er, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL mw2_latency got=%0d exp=6", lat); end
    total++; if (rd !== 16'hABCD) begin bad++; $display("FAIL mw2_rdata got=%h exp=abcd", rd); end
    total++; if (mem[7'h10] !== 16'h1B3D) begin bad++; $display("FAIL mw2_wdata got=%h exp=1b3d", mem[7'h10]); end
  endtask

  task automatic test_reset_flow();
    bit got; logic [15:0] rd; logic [1:0] er; int lat;
    mem[7'h20] = 16'h00F0; drdy_k = 2;
    do_req(7'h20, 16'h0000, 16'h5A5A, 1'b1, got, rd, er, lat);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL rf_resp got=%b exp=1", got); end
    total++; if (lat !== 21) begin bad++; $display("FAIL rf_latency got=%0d exp=21", lat); end
    total++; if (rd !== 16'h00F0) begin bad++; $display("FAIL rf_rdata got=%h exp=00f0", rd); end
    total++; if (er !== 2'd0) begin bad++; $display("FAIL rf_err got=%0d exp=0", er); end
    total++; if (rd_rst_run < 4) begin bad++; $display("FAIL rf_hold_cycles got=%0d exp>=4", rd_rst_run); end
    total++; if (rst_at_wr_drdy !== 1'b1) begin bad++; $display("FAIL rf_rst_at_wr_drdy got=%b exp=1", rst_at_wr_drdy); end
    total++; if (rst_after_wr_drdy !== 1'b0) begin bad++; $display("FAIL rf_rst_after got=%b exp=0", rst_after_wr_drdy); end
    total++; if (last_wr_di !== 16'h5A5A) begin bad++; $display("FAIL rf_wdata got=%h exp=5a5a", last_wr_di); end
  endtask

  task automatic test_drdy_timeout();
    bit got; logic [15:0] rd; logic [1:0] er; int lat; int wc0;
    drdy_en = 1'b0; wc0 = wr_count;
    do_req(7'h30, 16'h0000, 16'hFFFF, 1'b0, got, rd, er, lat);
    total++; if (er !== 2'd1) begin bad++; $display("FAIL dt_err got=%0d exp=1", er); end
    total++; if (lat !== 19) begin bad++; $display("FAIL dt_latency got=%0d exp=19", lat); end
    do_req(7'h31, 16'h0000, 16'hFFFF, 1'b1, got, rd, er, lat);
    total++; if (er !== 2'd1) begin bad++; $display("FAIL dth_err got=%0d exp=1", er); end
    total++; if (lat !== 23) begin bad++; $display("FAIL dth_latency got=%0d exp=23", lat); end
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL dth_pll_rst got=%b exp=0", pll_rst); end
    total++; if (wr_count - wc0 !== 0) begin bad++; $display("FAIL dt_no_write got=%0d exp=0", wr_count - wc0); end
    drdy_en = 1'b1;
  endtask

  task automatic test_lock_timeout();
    bit got; logic [15:0] rd; logic [1:0] er; int lat; int rc0;
    lock_en = 1'b0; drdy_k = 1; rc0 = resp_count;
    do_req(7'h22, 16'hFFFF, 16'h0000, 1'b1, got, rd, er, lat);
    total++; if (er !== 2'd2) begin bad++; $display("FAIL lt_err got=%0d exp=2", er); end
    total++; if (lat !== 110) begin bad++; $display("FAIL lt_latency got=%0d exp=110", lat); end
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lt_ready got=%b exp=1", req_ready); end
    repeat (3) @(negedge clk);
    total++; if (resp_count - rc0 !== 1) begin bad++; $display("FAIL lt_resp_once got=%0d exp=1", resp_count - rc0); end
    lock_en = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    bit got; bit seen; logic [15:0] rd; logic [1:0] er; int lat; int rc0;
    drdy_k = 5; mem[7'h50] = 16'h1111; rc0 = resp_count; seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'h50; req_mask = 16'h0000; req_data = 16'h2222; req_reset_pll = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (drp_den && drp_dwe) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rm_write_seen got=%b exp=1", seen); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (resp_count - rc0 !== 0) begin bad++; $display("FAIL rm_no_resp got=%0d exp=0", resp_count - rc0); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", req_ready); end
    total++; if ({drp_den, drp_dwe, drp_daddr, drp_di} !== 25'h0) begin bad++; $display("FAIL rm_drp_outs got=%h exp=0", {drp_den, drp_dwe, drp_daddr, drp_di}); end
    total++; if ({resp_rdata, resp_err} !== 18'h0) begin bad++; $display("FAIL rm_resp_outs got=%h exp=0", {resp_rdata, resp_err}); end
    drdy_k = 2; mem[7'h51] = 16'h3C3C;
    do_req(7'h51, 16'hF0F0, 16'h0505, 1'b0, got, rd, er, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL rm_next_latency got=%0d exp=8", lat); end
    total++; if (mem[7'h51] !== 16'h3535) begin bad++; $display("FAIL rm_next_wdata got=%h exp=3535", mem[7'h51]); end
  endtask

  task automatic test_back_to_back();
    int rc0, dc0, n, c0;
    int rc [2];
    logic [15:0] rdv [2];
    rc0 = resp_count; dc0 = den_count;
    @(negedge clk); stray_drdy = 1'b1;
    @(negedge clk); stray_drdy = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (resp_count - rc0 !== 0) begin bad++; $display("FAIL bb_stray_resp got=%0d exp=0", resp_count - rc0); end
    total++; if (den_count - dc0 !== 0) begin bad++; $display("FAIL bb_stray_den got=%0d exp=0", den_count - dc0); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bb_stray_ready got=%b exp=1", req_ready); end
    drdy_k = 1; mem[7'h40] = 16'h0000; n = 0; rc[0] = -1; rc[1] = -1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'h40; req_mask = 16'h00FF; req_data = 16'hAB00; req_reset_pll = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        rc[n] = cyc - c0; rdv[n] = resp_rdata; n++;
        if (n == 2) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (rc[0] !== 6) begin bad++; $display("FAIL bb_first_latency got=%0d exp=6", rc[0]); end
    total++; if (rc[1] !== 13) begin bad++; $display("FAIL bb_second_latency got=%0d exp=13", rc[1]); end
    total++; if (rdv[0] !== 16'h0000) begin bad++; $display("FAIL bb_first_rdata got=%h exp=0000", rdv[0]); end
    total++; if (rdv[1] !== 16'hAB00) begin bad++; $display("FAIL bb_second_rdata got=%h exp=ab00", rdv[1]); end
    total++; if (resp_count - rc0 !== 2) begin bad++; $display("FAIL bb_resp_count got=%0d exp=2", resp_count - rc0); end
    total++; if (den_count - dc0 !== 4) begin bad++; $display("FAIL bb_den_count got=%0d exp=4", den_count - dc0); end
    total++; if (viol !== 0) begin bad++; $display("FAIL bb_den_protocol got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_mask_write();
    test_reset_flow();
    test_drdy_timeout();
    test_lock_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
